bluetooth_rx_dma: RTL and testbench
===================================

# bluetooth_rx_dma

Avalon-MM write master that takes the received Bluetooth UART byte stream and stores it into the on-chip `bluetooth_RAM` through its s1/s2 slave port. Bytes are packed little-endian into 32-bit words and written with per-lane byteenable. Partial words are flushed on end-of-packet or on an idle timeout. The write pointer runs as a ring buffer over a configurable word window, and firmware reads the pointer to locate new data.

## Interface
- `BASE_WORD`, 0: first word address of the ring window.
- `DEPTH_WORDS`, 51200: ring size in 32-bit words; must be ≥2 and `BASE_WORD+DEPTH_WORDS` ≤ 65536.
- `IDLE_FLUSH`, 1024: idle cycles before a partial word is flushed; must be ≥1.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; when low, no new bytes are accepted.
- `clear` in 1: one-cycle pulse; drops buffered bytes, resets pointer and `wrapped`.
- `in_data` in 8: received byte.
- `in_valid` in 1: `in_data` is valid.
- `in_eop` in 1: qualifies the byte as the last byte of a packet.
- `in_ready` out 1: the byte is accepted on a cycle with `in_valid & in_ready`.
- `avm_address` out 16: word address.
- `avm_byteenable` out 4: filled lanes of the word.
- `avm_chipselect` out 1: equals `avm_write`.
- `avm_write` out 1: write request.
- `avm_writedata` out 32: packed word.
- `avm_waitrequest` in 1: slave stall; tie to 0 for `bluetooth_RAM`.
- `wr_ptr` out 16: word address of the next write.
- `wrapped` out 1: sticky; set when the pointer wraps.

## Operation
- Two states: FILL and WRITE.
- FILL:
  - `in_ready = enable`.
  - The accepted byte goes to lane `lane_cnt`, occupying bits `[8*k+7:8*k]`, and sets bit k of the byte mask.
  - `lane_cnt` increments.
- FILL → WRITE, evaluated on the accepting cycle, when any of these holds:
  - the 4th byte is accepted;
  - a byte with `in_eop=1` is accepted;
  - the idle counter reaches `IDLE_FLUSH` while the mask is nonzero.
- Idle counter:
  - Cleared on every accepted byte and whenever the mask is 0.
  - Otherwise increments every FILL cycle, including when `enable` is low.
  - Saturates at `IDLE_FLUSH`.
- WRITE:
  - `in_ready=0`.
  - `avm_write=avm_chipselect=1`, `avm_address=wr_ptr`, `avm_byteenable`=mask, `avm_writedata`=packed word.
  - Unfilled lanes drive 0.
  - All outputs are held stable while `avm_waitrequest=1`.
- Write acceptance (`avm_write & ~avm_waitrequest`):
  - Return to FILL.
  - Mask, `lane_cnt` and idle counter clear.
  - `wr_ptr` increments.
  - If `wr_ptr` was `BASE_WORD+DEPTH_WORDS-1`, it loads `BASE_WORD` and `wrapped` sets.
- After a partial flush, the next byte always starts at lane 0 of the next word.
- Overruns are not detected. The ring overwrites the oldest data, and firmware uses `wrapped` and `wr_ptr` to detect it.
- `clear` in FILL:
  - Mask, `lane_cnt` and idle counter clear.
  - `wr_ptr` loads `BASE_WORD` and `wrapped` clears.
  - A byte presented in the same cycle is not accepted (`in_ready` is forced 0 that cycle).
- `clear` in WRITE:
  - Registered as pending; the in-flight write completes first (the Avalon hold rule).
  - On acceptance the clear is applied instead of the pointer increment.
- Reset values:
  - Outputs: `in_ready=0`, `avm_write=avm_chipselect=0`, `avm_address=BASE_WORD`, `avm_byteenable=0`, `avm_writedata=0`, `wr_ptr=BASE_WORD`, `wrapped=0`.
  - Internal: state FILL, mask 0.
- Reset asserted mid-WRITE aborts the write immediately; the buffered bytes are lost.

## Timing
- A byte accepted in cycle N becomes visible in the buffer at N+1.
- A flush trigger in cycle N raises `avm_write` at N+1.
- With `avm_waitrequest=0`:
  - The write is accepted at N+1.
  - `in_ready` returns high at N+2 and `wr_ptr` updates at N+2.
  - Sustained throughput is 4 bytes per 5 cycles.
- Each cycle of `avm_waitrequest=1` extends WRITE by exactly one cycle.
- Idle flush: last byte accepted at cycle N (mask nonzero), no further bytes → `avm_write` rises at N+1+`IDLE_FLUSH`.
- `wr_ptr` and `wrapped` are registered and change only on the cycle after write acceptance or `clear`.

## Test plan
- Full word:
  - Stimulus: bytes 0x11, 0x22, 0x33, 0x44 back-to-back.
  - Response: one write at addr 0, data 0x44332211, be 0xF; `wr_ptr` becomes 1.
- End of packet:
  - Stimulus: 0xAA, then 0xBB with `in_eop=1`.
  - Response: write at addr 0, data 0x0000BBAA, be 0x3. The next byte 0xCC then lands at addr 1, lane 0.
- Idle flush:
  - Stimulus: `IDLE_FLUSH=8`, single byte 0x5A, then nothing.
  - Response: write exactly 9 cycles after acceptance, be 0x1, data 0x0000005A.
- Backpressure:
  - Stimulus: `avm_waitrequest` held high 3 cycles during a write.
  - Response: address, data and be remain stable for 4 cycles, `in_ready` stays 0, exactly one increment of `wr_ptr`.
- Wrap and clear:
  - Stimulus: `BASE_WORD=100`, `DEPTH_WORDS=4`, 20 bytes.
  - Response: writes to 100, 101, 102, 103, 100; `wrapped=1`, `wr_ptr=101`.
  - Stimulus: `clear` pulse during WRITE.
  - Response: the write completes, then `wr_ptr=100` and `wrapped=0`.
- Reset mid-write:
  - Stimulus: drop `reset_n` while `avm_write=1` and `avm_waitrequest=1`.
  - Response: `avm_write` goes low asynchronously, all outputs take their reset values, no write is accepted.

Source files
------------

// File: rtl/bluetooth_rx_dma.sv
// bluetooth_rx_dma
//   Avalon-MM write master that packs the received Bluetooth UART byte stream
//   little-endian into 32-bit words and writes them into bluetooth_RAM.
//   Writes go to a ring of DEPTH_WORDS words starting at BASE_WORD.
//   A partial word is flushed on end-of-packet or after IDLE_FLUSH idle cycles.
//
// Ports
//   clk, reset_n     : clock, asynchronous active-low reset
//   enable           : level; when low, no bytes are accepted
//   clear            : one-cycle pulse; drops buffered bytes, rewinds pointer
//   in_data/in_valid/in_eop/in_ready : byte stream input (valid/ready)
//   avm_*            : Avalon-MM write master (address in words)
//   wr_ptr           : word address of the next write
//   wrapped          : sticky, set when the pointer wraps to BASE_WORD
module bluetooth_rx_dma #(
  parameter int unsigned BASE_WORD   = 0,
  parameter int unsigned DEPTH_WORDS = 51200,
  parameter int unsigned IDLE_FLUSH  = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_eop,
  output logic        in_ready,
  output logic [15:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic [15:0] wr_ptr,
  output logic        wrapped
);

  localparam int unsigned IW = $clog2(IDLE_FLUSH + 1);
  localparam logic [15:0]   BASE_ADDR = 16'(BASE_WORD);
  localparam logic [15:0]   LAST_ADDR = 16'(BASE_WORD + DEPTH_WORDS - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_FLUSH);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_FLUSH - 1);

  if (DEPTH_WORDS < 2) begin : g_bad_depth
    $error("bluetooth_rx_dma: DEPTH_WORDS must be at least 2");
  end
  if (BASE_WORD + DEPTH_WORDS > 65536) begin : g_bad_window
    $error("bluetooth_rx_dma: ring window exceeds the 16-bit word space");
  end
  if (IDLE_FLUSH < 1) begin : g_bad_idle
    $error("bluetooth_rx_dma: IDLE_FLUSH must be at least 1");
  end

  typedef enum logic {
    FILL  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   word_q;
  logic [3:0]    mask_q;
  logic [1:0]    lane_q;
  logic [IW-1:0] idle_q;
  logic [15:0]   ptr_q;
  logic          wrapped_q;
  logic          clear_pend_q;
  logic          active_q;

  logic          accept;
  logic          flush;
  logic          wr_done;
  logic          fill_clear;

  // ---------------------------------------------------------------------------
  // Next-state and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    flush      = 1'b0;
    wr_done    = 1'b0;
    fill_clear = 1'b0;
    unique case (state)
      FILL: begin
        // active_q keeps in_ready low while and right after reset.
        in_ready = enable & active_q & ~clear;
        accept   = in_ready & in_valid;
        if (clear) begin
          fill_clear = 1'b1;
        end else if (accept) begin
          flush = (lane_q == 2'd3) | in_eop;
        end else if ((mask_q != '0) && (idle_q == IDLE_LAST)) begin
          // Counter is about to reach IDLE_FLUSH with bytes buffered.
          flush = 1'b1;
        end
        if (flush) state_nxt = WRITE;
      end
      WRITE: begin
        wr_done = ~avm_waitrequest;
        if (wr_done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Packing buffer, idle counter, ring pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q       <= '0;
      mask_q       <= '0;
      lane_q       <= '0;
      idle_q       <= '0;
      ptr_q        <= BASE_ADDR;
      wrapped_q    <= 1'b0;
      clear_pend_q <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      active_q <= 1'b1;
      if (fill_clear) begin
        word_q    <= '0;
        mask_q    <= '0;
        lane_q    <= '0;
        idle_q    <= '0;
        ptr_q     <= BASE_ADDR;
        wrapped_q <= 1'b0;
      end else if (state == FILL) begin
        if (accept) begin
          for (int unsigned k = 0; k < 4; k++) begin
            if (lane_q == 2'(k)) word_q[8*k +: 8] <= in_data;
          end
          mask_q[lane_q] <= 1'b1;
          lane_q         <= lane_q + 2'd1;
          idle_q         <= '0;
        end else if (mask_q == '0) begin
          idle_q <= '0;
        end else if (idle_q != IDLE_MAX) begin
          idle_q <= idle_q + IW'(1);
        end
      end else begin
        // A clear during WRITE waits for the in-flight write to be accepted,
        // then replaces the pointer increment.
        if (clear) clear_pend_q <= 1'b1;
        if (wr_done) begin
          word_q       <= '0;
          mask_q       <= '0;
          lane_q       <= '0;
          idle_q       <= '0;
          clear_pend_q <= 1'b0;
          if (clear_pend_q || clear) begin
            ptr_q     <= BASE_ADDR;
            wrapped_q <= 1'b0;
          end else if (ptr_q == LAST_ADDR) begin
            ptr_q     <= BASE_ADDR;
            wrapped_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + 16'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Avalon outputs: decoded from state so reset drops them asynchronously.
  // Unfilled lanes of word_q are always zero.
  // ---------------------------------------------------------------------------
  assign avm_write      = (state == WRITE);
  assign avm_chipselect = avm_write;
  assign avm_address    = ptr_q;
  assign avm_byteenable = avm_write ? mask_q : '0;
  assign avm_writedata  = avm_write ? word_q : '0;
  assign wr_ptr         = ptr_q;
  assign wrapped        = wrapped_q;

endmodule

// File: tb/tb_bluetooth_rx_dma.sv
// Self-checking bench for bluetooth_rx_dma (BASE_WORD=100, DEPTH_WORDS=4,
// IDLE_FLUSH=8): directed vector table, hand-written corner sequences and a
// randomized byte stream checked against a word-segmentation model.
module tb_bluetooth_rx_dma;
  localparam int unsigned BASE  = 100;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDLE  = 8;

  logic        clk = 1'b0;
  logic        reset_n, enable, clear, in_valid, in_eop, avm_waitrequest;
  logic [7:0]  in_data;
  logic        in_ready, avm_chipselect, avm_write, wrapped;
  logic [15:0] avm_address, wr_ptr;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;

  bluetooth_rx_dma #(
    .BASE_WORD  (BASE),
    .DEPTH_WORDS(DEPTH),
    .IDLE_FLUSH (IDLE)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .clear          (clear),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_eop         (in_eop),
    .in_ready       (in_ready),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .wr_ptr         (wr_ptr),
    .wrapped        (wrapped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed write transactions
  typedef struct {
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          rise;
  } wr_t;

  wr_t  wq[$];
  int   last_rise = 0;
  logic prev_w = 1'b0;

  always @(negedge clk) begin
    if (avm_write && !prev_w) last_rise = cyc;
    prev_w = avm_write;
    if (reset_n && avm_write && !avm_waitrequest)
      wq.push_back('{avm_address, avm_byteenable, avm_writedata, last_rise});
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  bit rand_wp = 1'b0;
  int last_acc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_wp) avm_waitrequest = ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    bit got = 1'b0;
    in_data  = b;
    in_eop   = e;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got      = 1'b1;
        last_acc = cyc;
      end
      tick();
    end
    in_valid = 1'b0;
    in_eop   = 1'b0;
    chk("byte_accept", 32'(got), 32'd1);
  endtask

  task automatic wait_writes(input int n);
    int i = 0;
    while (wq.size() < n && i < 200) begin
      tick();
      i++;
    end
    chk("write_count", wq.size(), n);
  endtask

  // Directed vectors: bytes packed LSB-first, eop applies to the last byte
  typedef struct {
    int          n;
    logic [31:0] bytes;
    logic        eop;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          lat;
  } vec_t;

  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t         exp_q[$];
    logic [31:0] cur_data;
    int          cur_n, nw, p;
    logic [7:0]  b;
    logic        e;
    bit          big;

    vt[0] = '{4, 32'h44332211, 1'b0, 16'd100, 4'hF, 32'h44332211, 1};
    vt[1] = '{2, 32'h0000BBAA, 1'b1, 16'd101, 4'h3, 32'h0000BBAA, 1};
    vt[2] = '{1, 32'h000000CC, 1'b1, 16'd102, 4'h1, 32'h000000CC, 1};
    vt[3] = '{1, 32'h0000005A, 1'b0, 16'd103, 4'h1, 32'h0000005A, 1 + IDLE};
    vt[4] = '{3, 32'h00030201, 1'b1, 16'd100, 4'h7, 32'h00030201, 1};
    vt[5] = '{4, 32'hDDCCBBAA, 1'b1, 16'd101, 4'hF, 32'hDDCCBBAA, 1};

    reset_n = 1'b0; enable = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_eop = 1'b0; in_data = '0; avm_waitrequest = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_addr", avm_address, BASE);
    chk("rst_be", avm_byteenable, 0);
    chk("rst_data", avm_writedata, 0);
    chk("rst_wr_ptr", wr_ptr, BASE);
    chk("rst_wrapped", wrapped, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // Directed vector table
    for (int r = 0; r < 6; r++) begin
      wq.delete();
      for (int k = 0; k < vt[r].n; k++)
        send_byte(vt[r].bytes[8*k +: 8], (k == vt[r].n - 1) ? vt[r].eop : 1'b0);
      wait_writes(1);
      if (wq.size() > 0) begin
        chk($sformatf("vec%0d_addr", r), wq[0].addr, vt[r].addr);
        chk($sformatf("vec%0d_be", r), wq[0].be, vt[r].be);
        chk($sformatf("vec%0d_data", r), wq[0].data, vt[r].data);
        chk($sformatf("vec%0d_latency", r), wq[0].rise - last_acc, vt[r].lat);
      end
    end
    tick();
    chk("vec_wr_ptr", wr_ptr, 102);
    chk("vec_wrapped", wrapped, 1);

    // Backpressure: waitrequest high for 3 write cycles, low on the 4th
    wq.delete();
    avm_waitrequest = 1'b1;
    for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0);
    in_data  = 8'h99;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        avm_waitrequest = 1'b0;
        in_valid        = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("bp%0d_write", k), avm_write, 1);
      chk($sformatf("bp%0d_cs", k), avm_chipselect, 1);
      chk($sformatf("bp%0d_addr", k), avm_address, 102);
      chk($sformatf("bp%0d_data", k), avm_writedata, 32'h04030201);
      chk($sformatf("bp%0d_be", k), avm_byteenable, 4'hF);
      chk($sformatf("bp%0d_ready", k), in_ready, 0);
      chk($sformatf("bp%0d_ptr", k), wr_ptr, 102);
      tick();
    end
    @(negedge clk);
    chk("bp_write_done", avm_write, 0);
    chk("bp_one_write", wq.size(), 1);
    chk("bp_wr_ptr", wr_ptr, 103);
    chk("bp_ready_back", in_ready, 1);
    tick();

    // enable low, then clear in FILL with a byte presented
    enable   = 1'b0;
    in_data  = 8'h77;
    in_valid = 1'b1;
    @(negedge clk);
    chk("enable_low_ready", in_ready, 0);
    tick();
    enable = 1'b1;
    clear  = 1'b1;
    @(negedge clk);
    chk("clear_ready", in_ready, 0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_wr_ptr", wr_ptr, BASE);
    chk("clear_wrapped", wrapped, 0);
    tick();

    // Randomized stream against word-segmentation model
    wq.delete();
    rand_wp  = 1'b1;
    cur_data = '0;
    cur_n    = 0;
    nw       = 0;
    for (int i = 0; i < 120; i++) begin
      b   = 8'($urandom_range(0, 255));
      e   = ($urandom_range(0, 7) == 0);
      big = (i == 119) || ($urandom_range(0, 9) == 0);
      send_byte(b, e);
      cur_data = cur_data | (32'(b) << (8 * cur_n));
      cur_n++;
      if (cur_n == 4 || e || big) begin
        exp_q.push_back('{16'(BASE + (nw % DEPTH)), 4'((1 << cur_n) - 1), cur_data, 0});
        nw++;
        cur_n    = 0;
        cur_data = '0;
      end
      idle(big ? int'(IDLE) + 6 : int'($urandom_range(0, 2)));
    end
    wait_writes(exp_q.size());
    rand_wp         = 1'b0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      chk($sformatf("rnd%0d_addr", i), wq[i].addr, exp_q[i].addr);
      chk($sformatf("rnd%0d_be", i), wq[i].be, exp_q[i].be);
      chk($sformatf("rnd%0d_data", i), wq[i].data, exp_q[i].data);
    end
    tick();
    chk("rnd_wr_ptr", wr_ptr, BASE + (nw % DEPTH));
    chk("rnd_wrapped", wrapped, (nw >= DEPTH) ? 1 : 0);

    // clear during a stalled write
    p = BASE + (nw % DEPTH);
    wq.delete();
    avm_waitrequest = 1'b1;
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("cw_hold_ptr", wr_ptr, p);
    chk("cw_hold_write", avm_write, 1);
    tick();
    avm_waitrequest = 1'b0;
    tick();
    tick();
    chk("cw_count", wq.size(), 1);
    if (wq.size() > 0) begin
      chk("cw_addr", wq[0].addr, p);
      chk("cw_data", wq[0].data, 32'h0000ADDE);
      chk("cw_be", wq[0].be, 4'h3);
    end
    chk("cw_wr_ptr", wr_ptr, BASE);
    chk("cw_wrapped", wrapped, 0);

    // Reset asserted in the middle of a stalled write
    wq.delete();
    for (int k = 0; k < 4; k++) send_byte(8'hA1 + 8'(k), 1'b0);
    wait_writes(1);
    avm_waitrequest = 1'b1;
    send_byte(8'hB1, 1'b1);
    @(negedge clk);
    chk("rmw_pre_write", avm_write, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rmw_write", avm_write, 0);
    chk("rmw_cs", avm_chipselect, 0);
    chk("rmw_addr", avm_address, BASE);
    chk("rmw_be", avm_byteenable, 0);
    chk("rmw_data", avm_writedata, 0);
    chk("rmw_wr_ptr", wr_ptr, BASE);
    chk("rmw_wrapped", wrapped, 0);
    chk("rmw_ready", in_ready, 0);
    idle(3);
    reset_n         = 1'b1;
    avm_waitrequest = 1'b0;
    idle(20);
    chk("rmw_no_write", wq.size(), 1);
    chk("rmw_ptr_after", wr_ptr, BASE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
